// File: rtl/sc_speed_level_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sc_speed_level_counter_if
//  Description : Control/status bundle for the speed level counter.
//                slave  - the counter: takes the active-low step/clear/load
//                         requests, the load value and the tick enable;
//                         returns the level, the speed tick and the
//                         bound flags.
//                master - the controller driving the counter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sc_speed_level_counter_if #(
    parameter int DATAWIDTH = 8
);
    logic                 upcount_InLow;
    logic                 downcount_InLow;
    logic                 clear_InLow;
    logic                 load_InLow;
    logic [DATAWIDTH-1:0] load_data_InBUS;
    logic                 tick_enable_InHigh;
    logic [DATAWIDTH-1:0] level_OutBUS;
    logic                 tick_Out;
    logic                 atmax_Out;
    logic                 atmin_Out;

    modport master (
        output upcount_InLow,
        output downcount_InLow,
        output clear_InLow,
        output load_InLow,
        output load_data_InBUS,
        output tick_enable_InHigh,
        input  level_OutBUS,
        input  tick_Out,
        input  atmax_Out,
        input  atmin_Out
    );

    modport slave (
        input  upcount_InLow,
        input  downcount_InLow,
        input  clear_InLow,
        input  load_InLow,
        input  load_data_InBUS,
        input  tick_enable_InHigh,
        output level_OutBUS,
        output tick_Out,
        output atmax_Out,
        output atmin_Out
    );
endinterface
`default_nettype wire

// File: rtl/sc_speed_level_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sc_speed_level_counter
//  Description : Speed level counter with a level-dependent tick generator.
//                The level (0..MAXLEVEL) steps once per falling edge of the
//                active-low up/down requests, can be cleared or loaded, and
//                saturates or wraps at the bounds. A phase counter emits a
//                one-cycle tick every max(BASE_PERIOD - level*STEP,
//                MIN_PERIOD) cycles while enabled.
//  Ports       : SC_upSPEEDCOUNTER_CLOCK_50     - clock, rising edge
//                SC_upSPEEDCOUNTER_RESET_InHigh - asynchronous reset, high
//                bus (slave modport)            - requests in, level/tick/
//                                                 bound flags out
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_speed_level_counter #(
    parameter int DATAWIDTH   = 8,
    parameter int MAXLEVEL    = 15,
    parameter int SATURATE    = 1,
    parameter int PERIODWIDTH = 24,
    parameter int BASE_PERIOD = 5000000,
    parameter int STEP        = 250000,
    parameter int MIN_PERIOD  = 500000
) (
    input  wire logic                SC_upSPEEDCOUNTER_CLOCK_50,
    input  wire logic                SC_upSPEEDCOUNTER_RESET_InHigh,
    sc_speed_level_counter_if.slave  bus
);

    // level*STEP is held in a product wide enough for any level and step
    localparam int c_PRODW = DATAWIDTH + PERIODWIDTH;
    localparam int c_HEADROOM_INT = (BASE_PERIOD > MIN_PERIOD) ? (BASE_PERIOD - MIN_PERIOD) : 0;

    localparam logic [DATAWIDTH-1:0]   c_MAX      = DATAWIDTH'(MAXLEVEL);
    localparam logic [c_PRODW-1:0]     c_STEP     = c_PRODW'(STEP);
    localparam logic [c_PRODW-1:0]     c_BASE     = c_PRODW'(BASE_PERIOD);
    localparam logic [c_PRODW-1:0]     c_MIN      = c_PRODW'(MIN_PERIOD);
    localparam logic [c_PRODW-1:0]     c_HEADROOM = c_PRODW'(c_HEADROOM_INT);

    logic [DATAWIDTH-1:0]   r_level;
    logic [PERIODWIDTH-1:0] r_phase;
    logic                   r_tick;
    logic                   r_upPrev;
    logic                   r_downPrev;
    logic                   r_armed;

    logic                   w_upEdge;
    logic                   w_downEdge;
    logic                   w_restart;
    logic [DATAWIDTH-1:0]   w_levelNext;
    logic [c_PRODW-1:0]     w_product;
    logic [c_PRODW-1:0]     w_periodWide;
    logic [PERIODWIDTH-1:0] w_period;
    logic [PERIODWIDTH-1:0] w_periodM1;

    // r_armed stays low for the first edge after reset so that a request
    // already held low at release is absorbed into the registered copy
    // instead of being seen as a fresh transition.
    assign w_upEdge   = r_armed & r_upPrev   & ~bus.upcount_InLow;
    assign w_downEdge = r_armed & r_downPrev & ~bus.downcount_InLow;
    assign w_restart  = ~bus.clear_InLow | ~bus.load_InLow;

    // Comparing the product against the headroom (BASE - MIN) selects the
    // floor before any subtraction, so the period never underflows.
    assign w_product    = {{PERIODWIDTH{1'b0}}, r_level} * c_STEP;
    assign w_periodWide = (w_product >= c_HEADROOM) ? c_MIN : (c_BASE - w_product);
    assign w_period     = w_periodWide[PERIODWIDTH-1:0];
    assign w_periodM1   = w_period - PERIODWIDTH'(1);

    always_comb begin
        w_levelNext = r_level;
        if (!bus.clear_InLow) begin
            w_levelNext = '0;
        end else if (!bus.load_InLow) begin
            w_levelNext = (bus.load_data_InBUS > c_MAX) ? c_MAX : bus.load_data_InBUS;
        end else if (w_upEdge && !w_downEdge) begin
            if (r_level >= c_MAX)
                w_levelNext = (SATURATE != 0) ? c_MAX : '0;
            else
                w_levelNext = r_level + DATAWIDTH'(1);
        end else if (w_downEdge && !w_upEdge) begin
            if (r_level == '0)
                w_levelNext = (SATURATE != 0) ? '0 : c_MAX;
            else
                w_levelNext = r_level - DATAWIDTH'(1);
        end
    end

    always_ff @(posedge SC_upSPEEDCOUNTER_CLOCK_50 or posedge SC_upSPEEDCOUNTER_RESET_InHigh) begin
        if (SC_upSPEEDCOUNTER_RESET_InHigh) begin
            r_level    <= '0;
            r_phase    <= '0;
            r_tick     <= 1'b0;
            r_upPrev   <= 1'b1;
            r_downPrev <= 1'b1;
            r_armed    <= 1'b0;
        end else begin
            r_upPrev   <= bus.upcount_InLow;
            r_downPrev <= bus.downcount_InLow;
            r_armed    <= 1'b1;
            r_level    <= w_levelNext;
            r_tick     <= 1'b0;
            if (w_restart) begin
                r_phase <= '0;
            end else if (bus.tick_enable_InHigh) begin
                // ">=" rather than "==": a level change that shortens the
                // period below the current phase ticks at once instead of
                // wrapping the counter.
                if (r_phase >= w_periodM1) begin
                    r_phase <= '0;
                    r_tick  <= 1'b1;
                end else begin
                    r_phase <= r_phase + PERIODWIDTH'(1);
                end
            end
        end
    end

    assign bus.level_OutBUS = r_level;
    assign bus.tick_Out     = r_tick;
    assign bus.atmax_Out    = (r_level == c_MAX);
    assign bus.atmin_Out    = (r_level == '0);

endmodule
`default_nettype wire

// File: tb/tb_sc_speed_level_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_speed_level_counter
//  Description : Self-checking bench for sc_speed_level_counter. Two copies
//                (SATURATE=1 and SATURATE=0) share one stimulus stream and
//                are compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_speed_level_counter;

    localparam int c_DW    = 4;
    localparam int c_MAXL  = 5;
    localparam int c_BASEP = 10;
    localparam int c_STEPP = 2;
    localparam int c_MINP  = 4;
    localparam int c_PW    = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            up = 1'b1, dn = 1'b1, clr = 1'b1, ld = 1'b1, en = 1'b0;
    logic [c_DW-1:0] ldData = '0;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    sc_speed_level_counter_if #(.DATAWIDTH(c_DW)) bus1 ();
    sc_speed_level_counter_if #(.DATAWIDTH(c_DW)) bus0 ();

    assign bus1.upcount_InLow      = up;
    assign bus1.downcount_InLow    = dn;
    assign bus1.clear_InLow        = clr;
    assign bus1.load_InLow         = ld;
    assign bus1.load_data_InBUS    = ldData;
    assign bus1.tick_enable_InHigh = en;
    assign bus0.upcount_InLow      = up;
    assign bus0.downcount_InLow    = dn;
    assign bus0.clear_InLow        = clr;
    assign bus0.load_InLow         = ld;
    assign bus0.load_data_InBUS    = ldData;
    assign bus0.tick_enable_InHigh = en;

    sc_speed_level_counter #(
        .DATAWIDTH(c_DW), .MAXLEVEL(c_MAXL), .SATURATE(1), .PERIODWIDTH(c_PW),
        .BASE_PERIOD(c_BASEP), .STEP(c_STEPP), .MIN_PERIOD(c_MINP)
    ) dutSat (
        .SC_upSPEEDCOUNTER_CLOCK_50     (clk),
        .SC_upSPEEDCOUNTER_RESET_InHigh (rst),
        .bus                            (bus1)
    );

    sc_speed_level_counter #(
        .DATAWIDTH(c_DW), .MAXLEVEL(c_MAXL), .SATURATE(0), .PERIODWIDTH(c_PW),
        .BASE_PERIOD(c_BASEP), .STEP(c_STEPP), .MIN_PERIOD(c_MINP)
    ) dutWrap (
        .SC_upSPEEDCOUNTER_CLOCK_50     (clk),
        .SC_upSPEEDCOUNTER_RESET_InHigh (rst),
        .bus                            (bus0)
    );

    // ---------------- reference model (index 1 = saturating, 0 = wrapping)
    int mLevel[2];
    int mPhase[2];
    bit mTick[2];
    bit mUpPrev, mDnPrev, mArmed;

    function automatic int mPeriod(input int lvl);
        int p;
        p = c_BASEP - lvl * c_STEPP;
        return (p < c_MINP) ? c_MINP : p;
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 2; s++) begin
            mLevel[s] = 0; mPhase[s] = 0; mTick[s] = 1'b0;
        end
        mUpPrev = 1'b1; mDnPrev = 1'b1; mArmed = 1'b0;
    endtask

    task automatic modelStep();
        bit upE, dnE;
        int per, lv;
        upE = mArmed && mUpPrev && !up;
        dnE = mArmed && mDnPrev && !dn;
        for (int s = 0; s < 2; s++) begin
            per = mPeriod(mLevel[s]);
            lv  = mLevel[s];
            mTick[s] = 1'b0;
            if (!clr) begin
                mLevel[s] = 0; mPhase[s] = 0;
            end else if (!ld) begin
                mLevel[s] = (int'(ldData) > c_MAXL) ? c_MAXL : int'(ldData);
                mPhase[s] = 0;
            end else begin
                if (upE && !dnE)
                    mLevel[s] = (lv == c_MAXL) ? ((s == 1) ? c_MAXL : 0) : lv + 1;
                else if (dnE && !upE)
                    mLevel[s] = (lv == 0) ? ((s == 1) ? 0 : c_MAXL) : lv - 1;
                if (en) begin
                    if (mPhase[s] >= per - 1) begin
                        mTick[s] = 1'b1; mPhase[s] = 0;
                    end else begin
                        mPhase[s] = mPhase[s] + 1;
                    end
                end
            end
        end
        mUpPrev = up; mDnPrev = dn; mArmed = 1'b1;
    endtask

    // ---------------- checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, ".lvlSat"},  32'(bus1.level_OutBUS), mLevel[1]);
        chk({tag, ".tickSat"}, 32'(bus1.tick_Out),     32'(mTick[1]));
        chk({tag, ".maxSat"},  32'(bus1.atmax_Out),    32'(mLevel[1] == c_MAXL));
        chk({tag, ".minSat"},  32'(bus1.atmin_Out),    32'(mLevel[1] == 0));
        chk({tag, ".lvlWrp"},  32'(bus0.level_OutBUS), mLevel[0]);
        chk({tag, ".tickWrp"}, 32'(bus0.tick_Out),     32'(mTick[0]));
        chk({tag, ".maxWrp"},  32'(bus0.atmax_Out),    32'(mLevel[0] == c_MAXL));
        chk({tag, ".minWrp"},  32'(bus0.atmin_Out),    32'(mLevel[0] == 0));
    endtask

    // one clock: model advances on the rising edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        if (!rst) modelStep();
        @(negedge clk);
        checkAll("cyc");
    endtask

    // reset asserted between edges; outputs must react before any clock edge
    task automatic doReset();
        #5 rst = 1'b1;
        #1 modelReset();
        checkAll("asyncRst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulseUp();
        up = 1'b0; cycle(); up = 1'b1; cycle();
    endtask

    task automatic pulseDn();
        dn = 1'b0; cycle(); dn = 1'b1; cycle();
    endtask

    task automatic setLevel(input int l);
        ld = 1'b0; ldData = c_DW'(l); cycle(); ld = 1'b1;
    endtask

    task automatic clearPulse();
        clr = 1'b0; cycle(); clr = 1'b1;
    endtask

    task automatic waitTick(input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (bus1.tick_Out !== 1'b1 && n < budget);
        if (bus1.tick_Out !== 1'b1) begin
            chk("tickTimeout", 32'(bus1.tick_Out), 1);
            n = -1;
        end
    endtask

    task automatic measure(input int expPeriod, input string tag);
        int n;
        waitTick(40, n);
        waitTick(40, n);
        chk(tag, n, expPeriod);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seqWrap[7] = '{1, 2, 3, 4, 5, 0, 1};

        modelReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkAll("reset");
        rst = 1'b0;

        // request already low when reset releases must not count
        up = 1'b0;
        doReset();
        repeat (3) cycle();
        chk("heldAtRelease", 32'(bus1.level_OutBUS), 0);
        up = 1'b1; cycle();

        // holding up low steps exactly once
        up = 1'b0;
        repeat (20) cycle();
        up = 1'b1; cycle();
        chk("holdUpSat", 32'(bus1.level_OutBUS), 1);
        chk("holdUpWrp", 32'(bus0.level_OutBUS), 1);

        // seven separate up pulses from 0
        clearPulse();
        for (int i = 0; i < 7; i++) begin
            pulseUp();
            chk("wrapSeq", 32'(bus0.level_OutBUS), seqWrap[i]);
        end
        chk("satTop", 32'(bus1.level_OutBUS), 5);
        chk("satTopFlag", 32'(bus1.atmax_Out), 1);

        // simultaneous up and down hold; down at zero
        setLevel(3);
        up = 1'b0; dn = 1'b0; cycle();
        up = 1'b1; dn = 1'b1; cycle();
        chk("bothEdgesSat", 32'(bus1.level_OutBUS), 3);
        chk("bothEdgesWrp", 32'(bus0.level_OutBUS), 3);
        clearPulse();
        pulseDn();
        chk("downAtZeroSat", 32'(bus1.level_OutBUS), 0);
        chk("downAtZeroWrp", 32'(bus0.level_OutBUS), 5);

        // tick periods per level
        clearPulse();
        en = 1'b1;
        measure(10, "period0");
        setLevel(2);
        measure(6, "period2");
        setLevel(5);
        measure(4, "period5");

        // load clamp, then clear and load together restart the phase
        setLevel(9);
        chk("loadClampSat", 32'(bus1.level_OutBUS), 5);
        chk("loadClampWrp", 32'(bus0.level_OutBUS), 5);
        clr = 1'b0; ld = 1'b0; ldData = 4'd9; cycle();
        clr = 1'b1; ld = 1'b1;
        chk("clrBeatsLoad", 32'(bus1.level_OutBUS), 0);
        waitTick(40, n);
        chk("phaseZeroed", n, 10);

        // load at phase 8 gives no tick
        clearPulse();
        repeat (8) cycle();
        ld = 1'b0; ldData = 4'd5; cycle();
        chk("noTickOnLoad", 32'(bus1.tick_Out), 0);
        ld = 1'b1; cycle();
        chk("noTickAfterLoad", 32'(bus1.tick_Out), 0);

        // shortened period below the current phase ticks on the next cycle
        clearPulse();
        repeat (8) cycle();
        en = 1'b0;
        repeat (3) pulseUp();
        chk("levelThree", 32'(bus1.level_OutBUS), 3);
        en = 1'b1; cycle();
        chk("shortenedTick", 32'(bus1.tick_Out), 1);

        // randomized traffic
        repeat (500) begin
            up     = ($urandom % 3) != 0;
            dn     = ($urandom % 3) != 0;
            clr    = ($urandom % 40) != 0;
            ld     = ($urandom % 25) != 0;
            ldData = c_DW'($urandom);
            en     = ($urandom % 8) != 0;
            cycle();
            if ($urandom % 120 == 0) doReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
